// File: rtl/conway_engine_if.sv
// Control/status bundle between the Life engine and its display/scoreboard logic.
// The slave side is the engine; the master side drives commands and reads the grid.
interface conway_engine_if #(
   parameter int unsigned MAX_X = 32,
   parameter int unsigned MAX_Y = 24,
   parameter int unsigned CNT_W = 12,
   parameter int unsigned GEN_W = 16
);
   logic                   run;
   logic                   step;
   logic                   clear;
   logic                   draw;
   logic [7:0]             cursor_x;
   logic [7:0]             cursor_y;
   logic [63:0]            pattern_mat;
   logic [MAX_X*MAX_Y-1:0] state;
   logic [CNT_W-1:0]       alives;
   logic [GEN_W-1:0]       generation;
   logic                   busy;
   logic                   gen_done;

   modport master (
      output run, step, clear, draw, cursor_x, cursor_y, pattern_mat,
      input  state, alives, generation, busy, gen_done
   );

   modport slave (
      input  run, step, clear, draw, cursor_x, cursor_y, pattern_mat,
      output state, alives, generation, busy, gen_done
   );
endinterface

// File: rtl/conway_engine.sv
// Row-serial Life-like automaton: one grid row per clock, selectable torus/dead edges,
// configurable B/S rules, 8x8 pattern stamping and an exact live-cell recount.
module conway_engine #(
   parameter int unsigned MAX_X        = 32,
   parameter int unsigned MAX_Y        = 24,
   parameter int unsigned WRAP         = 1,
   parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
   parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
   parameter int unsigned CNT_W        = 12,
   parameter int unsigned GEN_W        = 16
) (
   input logic            clk,
   input logic            rst,
   conway_engine_if.slave bus
);
   localparam int unsigned     RW       = $clog2(MAX_Y);
   localparam int unsigned     XW       = $clog2(MAX_X);
   localparam logic [RW-1:0]   LAST_ROW = RW'(MAX_Y - 1);

   typedef enum logic [2:0] {IDLE, SWEEP, FINISH, STAMP, COUNT} fsm_t;

   fsm_t             fsm;
   fsm_t             fsm_nxt;

   logic [MAX_X-1:0] grid       [MAX_Y];
   logic [MAX_X-1:0] stamp_mask [MAX_Y];
   logic [MAX_X-1:0] prev_buf;
   logic [MAX_X-1:0] row0_buf;
   logic [MAX_X-1:0] cur_row;
   logic [MAX_X-1:0] nxt_row;
   logic [MAX_X-1:0] new_row;
   logic [RW-1:0]    r;
   logic             last_row;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] alives_q;
   logic [GEN_W-1:0] gen_q;
   logic [7:0]       stamp_x;
   logic [7:0]       stamp_y;
   logic [63:0]      stamp_pat;

   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_X-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < MAX_X; i++) c += CNT_W'(v[i]);
      return c;
   endfunction

   function automatic logic [MAX_X-1:0] glider_row(input int unsigned y);
      logic [MAX_X-1:0] g;
      g = '0;
      case (y)
         3: g[2] = 1'b1;
         4: g[3] = 1'b1;
         5: begin
            g[1] = 1'b1;
            g[2] = 1'b1;
            g[3] = 1'b1;
         end
         default: g = '0;
      endcase
      return g;
   endfunction

   // Rows are padded by one column each side so column x sees padded bits x..x+2.
   function automatic logic [MAX_X-1:0] next_row(input logic [MAX_X-1:0] above,
                                                 input logic [MAX_X-1:0] mid,
                                                 input logic [MAX_X-1:0] below);
      logic [MAX_X+1:0] ea;
      logic [MAX_X+1:0] em;
      logic [MAX_X+1:0] eb;
      logic [3:0]       n;
      logic [MAX_X-1:0] res;
      ea  = {(WRAP != 0) & above[0], above, (WRAP != 0) & above[MAX_X-1]};
      em  = {(WRAP != 0) & mid[0],   mid,   (WRAP != 0) & mid[MAX_X-1]};
      eb  = {(WRAP != 0) & below[0], below, (WRAP != 0) & below[MAX_X-1]};
      res = '0;
      for (int unsigned x = 0; x < MAX_X; x++) begin
         n = 4'(ea[x]) + 4'(ea[x+1]) + 4'(ea[x+2]) +
             4'(em[x]) + 4'(em[x+2]) +
             4'(eb[x]) + 4'(eb[x+1]) + 4'(eb[x+2]);
         res[x] = mid[x] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
      end
      return res;
   endfunction

   always_comb begin
      cur_row  = grid[r];
      last_row = (r == LAST_ROW);
      if (last_row) nxt_row = (WRAP != 0) ? row0_buf : '0;
      else          nxt_row = grid[r + 1'b1];
      new_row  = next_row(prev_buf, cur_row, nxt_row);
   end

   always_comb begin
      int unsigned xi;
      int unsigned yi;
      xi = 0;
      yi = 0;
      for (int unsigned y = 0; y < MAX_Y; y++) stamp_mask[y] = '0;
      for (int unsigned dy = 0; dy < 8; dy++) begin
         for (int unsigned dx = 0; dx < 8; dx++) begin
            xi = 32'(stamp_x) + dx;
            yi = 32'(stamp_y) + dy;
            if (WRAP != 0) begin
               xi = xi % MAX_X;
               yi = yi % MAX_Y;
            end
            if (stamp_pat[6'(dy*8 + dx)] && (32'(stamp_x) < MAX_X) && (32'(stamp_y) < MAX_Y) &&
                (xi < MAX_X) && (yi < MAX_Y))
               stamp_mask[yi[RW-1:0]][xi[XW-1:0]] = 1'b1;
         end
      end
   end

   for (genvar gy = 0; gy < MAX_Y; gy++) begin : g_pack
      assign bus.state[gy*MAX_X +: MAX_X] = grid[gy];
   end

   assign bus.alives     = alives_q;
   assign bus.generation = gen_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt      = fsm;
      bus.busy     = (fsm != IDLE);
      bus.gen_done = 1'b0;
      case (fsm)
         IDLE: begin
            if (!bus.clear) begin
               if (bus.draw)                  fsm_nxt = STAMP;
               else if (bus.run || bus.step)  fsm_nxt = SWEEP;
            end
         end
         SWEEP:   if (last_row) fsm_nxt = FINISH;
         FINISH: begin
            bus.gen_done = 1'b1;
            fsm_nxt      = IDLE;
         end
         STAMP:   fsm_nxt = COUNT;
         COUNT:   if (last_row) fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned y = 0; y < MAX_Y; y++) grid[y] <= glider_row(y);
         prev_buf  <= '0;
         row0_buf  <= '0;
         r         <= '0;
         acc       <= '0;
         alives_q  <= CNT_W'(5);
         gen_q     <= '0;
         stamp_x   <= '0;
         stamp_y   <= '0;
         stamp_pat <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (bus.clear) begin
                  for (int unsigned y = 0; y < MAX_Y; y++) grid[y] <= '0;
                  alives_q <= '0;
               end else if (bus.draw) begin
                  stamp_x   <= bus.cursor_x;
                  stamp_y   <= bus.cursor_y;
                  stamp_pat <= bus.pattern_mat;
               end else if (bus.run || bus.step) begin
                  r        <= '0;
                  acc      <= '0;
                  row0_buf <= grid[0];
                  prev_buf <= (WRAP != 0) ? grid[MAX_Y-1] : '0;
               end
            end
            // prev_buf keeps the pre-update copy of the row just overwritten.
            SWEEP: begin
               grid[r]  <= new_row;
               prev_buf <= cur_row;
               acc      <= acc + popcount(new_row);
               r        <= last_row ? '0 : r + 1'b1;
            end
            FINISH: begin
               alives_q <= acc;
               gen_q    <= gen_q + 1'b1;
            end
            STAMP: begin
               for (int unsigned y = 0; y < MAX_Y; y++) grid[y] <= grid[y] | stamp_mask[y];
               r   <= '0;
               acc <= '0;
            end
            COUNT: begin
               acc <= acc + popcount(cur_row);
               r   <= last_row ? '0 : r + 1'b1;
               if (last_row) alives_q <= acc + popcount(cur_row);
            end
            default: r <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_conway_engine.sv
// Scoreboarded bench for conway_engine: default, dead-edge and no-survive instances
// share one stimulus stream and are checked against a cell-by-cell reference model.
module tb_conway_engine;
   localparam int X = 32;
   localparam int Y = 24;
   localparam logic [8:0] BM = 9'b000001000;

   typedef logic [767:0] wide_t;
   typedef struct {
      wide_t g;
      int    a;
      int    gen;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0, step = 1'b0, clear = 1'b0, draw = 1'b0;
   logic [7:0]  cx = '0, cy = '0;
   logic [63:0] pat = '0;

   conway_engine_if bus0 ();
   conway_engine_if bus1 ();
   conway_engine_if bus2 ();

   assign bus0.run = run;  assign bus0.step = step;  assign bus0.clear = clear;  assign bus0.draw = draw;
   assign bus0.cursor_x = cx;  assign bus0.cursor_y = cy;  assign bus0.pattern_mat = pat;
   assign bus1.run = run;  assign bus1.step = step;  assign bus1.clear = clear;  assign bus1.draw = draw;
   assign bus1.cursor_x = cx;  assign bus1.cursor_y = cy;  assign bus1.pattern_mat = pat;
   assign bus2.run = run;  assign bus2.step = step;  assign bus2.clear = clear;  assign bus2.draw = draw;
   assign bus2.cursor_x = cx;  assign bus2.cursor_y = cy;  assign bus2.pattern_mat = pat;

   conway_engine u_dut (.clk(clk), .rst(rst), .bus(bus0));
   conway_engine #(.WRAP(0)) u_dut_nw (.clk(clk), .rst(rst), .bus(bus1));
   conway_engine #(.SURVIVE_MASK(9'b000000000)) u_dut_ns (.clk(clk), .rst(rst), .bus(bus2));

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   wide_t       mg   [3];
   int          ma   [3];
   int          mgen [3];
   bit          mwrap[3] = '{1'b1, 1'b0, 1'b1};
   logic [8:0]  msurv[3] = '{9'b000001100, 9'b000001100, 9'b000000000};
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q2[$];
   logic [2:0]  pb = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input wide_t got, input wide_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic wide_t at(input int x, input int y);
      wide_t g;
      g = '0;
      g[y*X + x] = 1'b1;
      return g;
   endfunction

   function automatic wide_t life_step(input wide_t g, input bit wrap, input logic [8:0] sm);
      wide_t r;
      int n, xx, yy;
      r = '0;
      for (int y = 0; y < Y; y++) begin
         for (int x = 0; x < X; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  if (dx == 0 && dy == 0) continue;
                  xx = x + dx;
                  yy = y + dy;
                  if (wrap) begin
                     xx = (xx + X) % X;
                     yy = (yy + Y) % Y;
                  end else if (xx < 0 || xx >= X || yy < 0 || yy >= Y) continue;
                  n += int'(g[yy*X + xx]);
               end
            end
            r[y*X + x] = g[y*X + x] ? sm[n] : BM[n];
         end
      end
      return r;
   endfunction

   function automatic wide_t stamp_model(input wide_t g, input bit wrap, input int x0, input int y0,
                                         input logic [63:0] p);
      int xx, yy;
      if (x0 >= X || y0 >= Y) return g;
      for (int dy = 0; dy < 8; dy++) begin
         for (int dx = 0; dx < 8; dx++) begin
            if (!p[dy*8 + dx]) continue;
            xx = x0 + dx;
            yy = y0 + dy;
            if (wrap) begin
               xx = xx % X;
               yy = yy % Y;
            end else if (xx >= X || yy >= Y) continue;
            g[yy*X + xx] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic wide_t glider();
      return at(2,3) | at(3,4) | at(3,5) | at(2,5) | at(1,5);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mg[i]   = glider();
         ma[i]   = 5;
         mgen[i] = 0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic push_all();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.g   = mg[i];
         e.a   = ma[i];
         e.gen = mgen[i];
         case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic m_step();
      for (int i = 0; i < 3; i++) begin
         mg[i] = life_step(mg[i], mwrap[i], msurv[i]);
         ma[i] = $countones(mg[i]);
         mgen[i]++;
      end
   endtask

   task automatic sb_pop(input int inst, input wide_t st, input int al, input int gn);
      exp_t e;
      int   sz;
      sz = (inst == 0) ? q0.size() : (inst == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         check($sformatf("sb_pending%0d", inst), wide_t'(sz), wide_t'(1));
         return;
      end
      case (inst)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      check($sformatf("sb_state%0d", inst), st, e.g);
      check($sformatf("sb_alives%0d", inst), wide_t'(al), wide_t'(e.a));
      check($sformatf("sb_gen%0d", inst), wide_t'(gn), wide_t'(e.gen));
   endtask

   // Each busy->idle transition marks a finished operation for that instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (pb[0] && !bus0.busy) sb_pop(0, bus0.state, int'(bus0.alives), int'(bus0.generation));
         if (pb[1] && !bus1.busy) sb_pop(1, bus1.state, int'(bus1.alives), int'(bus1.generation));
         if (pb[2] && !bus2.busy) sb_pop(2, bus2.state, int'(bus2.alives), int'(bus2.generation));
      end
      pb <= {bus2.busy, bus1.busy, bus0.busy};
   end

   task automatic wait_idle();
      int c;
      c = 0;
      while ((bus0.busy || bus1.busy || bus2.busy) && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("idle_timeout", wide_t'(bus0.busy | bus1.busy | bus2.busy), '0);
      @(negedge clk);
   endtask

   task automatic op_step();
      m_step();
      push_all();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_idle();
   endtask

   task automatic op_draw(input int x, input int y, input logic [63:0] p);
      cx  = 8'(x);
      cy  = 8'(y);
      pat = p;
      for (int i = 0; i < 3; i++) begin
         mg[i] = stamp_model(mg[i], mwrap[i], x, y, p);
         ma[i] = $countones(mg[i]);
      end
      push_all();
      draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      wait_idle();
   endtask

   task automatic op_clear();
      clear = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mg[i] = '0;
         ma[i] = 0;
      end
      @(negedge clk);
      clear = 1'b0;
      check("clear_state0", bus0.state, mg[0]);
      check("clear_alives1", wide_t'(bus1.alives), wide_t'(ma[1]));
      check("clear_busy", wide_t'(bus0.busy), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   gd;
      int   last;
      logic any_b;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_state", bus0.state, glider());
      check("rst_alives", wide_t'(bus0.alives), wide_t'(5));
      check("rst_gen", wide_t'(bus0.generation), '0);
      check("rst_busy", wide_t'(bus0.busy), '0);
      check("rst_gen_done", wide_t'(bus0.gen_done), '0);

      // Reset in the middle of a sweep
      run = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_sweep_busy", wide_t'(bus0.busy), wide_t'(1));
      #2 rst = 1'b1;
      #1;
      check("midrst_state", bus0.state, glider());
      check("midrst_alives", wide_t'(bus0.alives), wide_t'(5));
      check("midrst_gen", wide_t'(bus0.generation), '0);
      check("midrst_busy", wide_t'(bus0.busy), '0);
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);

      // Free-running for four generations
      for (int k = 0; k < 4; k++) begin
         m_step();
         push_all();
      end
      gd   = 0;
      last = 0;
      run  = 1'b1;
      for (int c = 0; c < 300 && gd < 4; c++) begin
         @(negedge clk);
         if (bus0.gen_done) begin
            gd++;
            if (gd > 1) check("gen_period", wide_t'(cyc - last), wide_t'(26));
            last = cyc;
            if (gd == 4) run = 1'b0;
         end
      end
      check("gen_done_count", wide_t'(gd), wide_t'(4));
      wait_idle();
      check("glider4_state", bus0.state, at(3,4) | at(4,5) | at(4,6) | at(3,6) | at(2,6));
      check("glider4_alives", wide_t'(bus0.alives), wide_t'(5));
      check("glider4_gen", wide_t'(bus0.generation), wide_t'(4));

      // Blinker in the middle of the grid
      op_clear();
      op_draw(10, 10, 64'h7);
      check("blink_state", bus0.state, at(10,10) | at(11,10) | at(12,10));
      check("blink_alives", wide_t'(bus0.alives), wide_t'(3));
      op_step();
      check("blink_step_state", bus0.state, at(11,9) | at(11,10) | at(11,11));
      check("blink_step_alives", wide_t'(bus0.alives), wide_t'(3));
      check("blink_step_gen", wide_t'(bus0.generation), wide_t'(5));

      // Blinker straddling the right/top edges
      op_clear();
      op_draw(31, 0, 64'h7);
      check("wrap_draw_state", bus0.state, at(31,0) | at(0,0) | at(1,0));
      check("edge_draw_state", bus1.state, at(31,0));
      check("edge_draw_alives", wide_t'(bus1.alives), wide_t'(1));
      op_step();
      check("wrap_step_state", bus0.state, at(0,23) | at(0,0) | at(0,1));
      check("edge_step_alives", wide_t'(bus1.alives), '0);

      // Block still life with commands issued while busy
      op_clear();
      op_draw(5, 5, 64'h303);
      check("block_alives", wide_t'(bus0.alives), wide_t'(4));
      m_step();
      push_all();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      check("busy_in_sweep", wide_t'(bus0.busy), wide_t'(1));
      cx = 8'd0; cy = 8'd0; pat = '1; draw = 1'b1;
      @(negedge clk);
      draw = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_idle();
      check("block_busy_state", bus0.state, at(5,5) | at(6,5) | at(5,6) | at(6,6));
      check("block_busy_alives", wide_t'(bus0.alives), wide_t'(4));
      check("nosurv_alives", wide_t'(bus2.alives), '0);
      any_b = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any_b |= bus0.busy;
      end
      check("no_queued_op", wide_t'(any_b), '0);
      check("sb_drained", wide_t'(q0.size() + q1.size() + q2.size()), '0);
      op_step();
      op_step();
      check("block3_state", bus0.state, at(5,5) | at(6,5) | at(5,6) | at(6,6));
      check("block3_alives", wide_t'(bus0.alives), wide_t'(4));

      // Clear outranks draw and step in the same cycle
      clear = 1'b1; draw = 1'b1; step = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mg[i] = '0;
         ma[i] = 0;
      end
      @(negedge clk);
      clear = 1'b0; draw = 1'b0; step = 1'b0;
      check("prio_busy", wide_t'(bus0.busy), '0);
      check("prio_state", bus0.state, '0);
      check("prio_alives", wide_t'(bus0.alives), '0);

      // Out-of-range cursor stamps nothing
      op_draw(2, 2, 64'h1);
      op_draw(40, 3, 64'hFF);
      op_draw(3, 40, 64'hFF);
      check("oob_alives", wide_t'(bus0.alives), wide_t'(1));
      check("oob_state", bus0.state, at(2,2));

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conway_engine.md
Name: conway_engine

Overview:
- Parametrised, row-serial Life-like cellular automaton engine for the ConwayGOL display path.
- Holds the cell grid, advances one generation per sweep (one row per clock), and supports selectable torus/dead-edge boundaries and configurable birth/survive rules.
- Adds single-step, clear, 8x8 pattern stamping at a cursor, and an exact live-cell count and generation counter for the display/scoreboard logic.

Parameters:
- MAX_X, 32, grid width in cells (>=4)
- MAX_Y, 24, grid height in cells (>=6)
- WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid read as dead
- BIRTH_MASK, 9'b000001000, bit n set -> dead cell with n live neighbours is born (B3)
- SURVIVE_MASK, 9'b000001100, bit n set -> live cell with n live neighbours survives (S23)
- CNT_W, 12, width of alives (must hold MAX_X*MAX_Y)
- GEN_W, 16, width of generation

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  level; start a new generation whenever IDLE
- step  in  1  pulse; one generation when IDLE and run=0
- clear  in  1  pulse; kill all cells
- draw  in  1  pulse; OR-stamp pattern_mat at the cursor
- cursor_x  in  8  stamp origin x (0..MAX_X-1)
- cursor_y  in  8  stamp origin y (0..MAX_Y-1)
- pattern_mat  in  64  bit dy*8+dx -> cell (cursor_x+dx, cursor_y+dy)
- state  out  MAX_X*MAX_Y  cell grid; cell (x,y) at bit y*MAX_X+x
- alives  out  CNT_W  live-cell count
- generation  out  GEN_W  generations computed since reset; wraps modulo 2^GEN_W
- busy  out  1  high in any state other than IDLE
- gen_done  out  1  one-cycle pulse when a generation completes

Behaviour:
- Reset (async, any state, including mid-sweep): state = glider {(2,3),(3,4),(3,5),(2,5),(1,5)}; alives=5; generation=0; busy=0; gen_done=0; FSM=IDLE.
- FSM states: IDLE, SWEEP, FINISH, STAMP, COUNT.
- IDLE priority: clear > draw > (run | step).
  - clear: state=0 and alives=0 on the next edge; FSM stays IDLE.
  - draw -> STAMP.
  - run or step -> SWEEP with row counter r=0, accumulator acc=0, and row0_buf and prev_buf captured from the original rows 0 and MAX_Y-1 (prev_buf=0 if WRAP=0).
- SWEEP, one row r per cycle:
  - New row r is computed from prev_buf (original row r-1), the current row r (still original), and row r+1 (original; for r=MAX_Y-1 use row0_buf if WRAP=1, else 0).
  - Columns wrap modulo MAX_X if WRAP=1; otherwise out-of-range columns read 0.
  - For neighbour count n (0..8): next = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n].
  - Write row r; prev_buf <= original row r; acc += popcount(new row r).
  - After r=MAX_Y-1 -> FINISH.
- FINISH (1 cycle): alives<=acc; generation+=1; gen_done=1; -> IDLE.
  - Generation period with run held high = MAX_Y+2 cycles.
- STAMP (1 cycle): for each set pattern bit, set cell (cursor_x+dx, cursor_y+dy).
  - WRAP=1: coordinates are taken modulo MAX_X/MAX_Y.
  - WRAP=0: cells beyond the edge are dropped.
  - cursor_x>=MAX_X or cursor_y>=MAX_Y: the stamp writes nothing.
  - Always -> COUNT.
- COUNT: MAX_Y cycles, acc += popcount(row r); then alives<=acc -> IDLE. generation is not changed.
- While busy, clear, draw and step are ignored (not queued). run is sampled only in IDLE.
- During SWEEP, state is partially updated (rows <r new, rows >=r old). Consumers qualify on busy=0 or on gen_done.
- alives is always exact (no incremental drift); alives never exceeds MAX_X*MAX_Y.

Test Plan:
1. Reset asserted mid-SWEEP -> immediately glider cells only, alives=5, generation=0, busy=0.
2. Default params (32x24), run=1 for 4 generations:
   - Cells {(3,4),(4,5),(4,6),(3,6),(2,6)}.
   - alives=5 after every gen_done.
   - gen_done spaced 26 cycles apart; generation=4.
3. clear, then draw pattern_mat=64'h7 at (10,10):
   - After COUNT, cells {(10,10),(11,10),(12,10)} and alives=3.
   - step -> {(11,9),(11,10),(11,11)}, alives=3, generation+1.
4. WRAP=1, clear, draw 64'h7 at (31,0):
   - Cells {(31,0),(0,0),(1,0)}.
   - step -> {(0,23),(0,0),(0,1)}.
5. WRAP=0, the same draw -> only (31,0) set, alives=1; step -> alives=0.
6. Busy and rule checks:
   - draw/step/clear asserted during SWEEP -> grid and alives unaffected beyond the normal generation.
   - SURVIVE_MASK=0 instance with a 2x2 block -> one step gives alives=0.
   - Default instance with a 2x2 block -> block unchanged after 3 steps.
